// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic/shift ops plus an optional
// WIDTH-cycle shift-add multiplier, enabled by defining ALU_MUL_EN.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for START; DONE pulses here after a completion
// ST_EXEC | one cycle to evaluate a non-MUL op (or flag an illegal op)
// ST_MUL  | one shift-add iteration per cycle (ALU_MUL_EN only)
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic [3:0]       OPCODE,
   input  logic             SIGNED_MODE,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             OE,
   output logic [WIDTH-1:0] ALU_OUT,
   output logic [WIDTH-1:0] PROD_HI,
   output logic             OF,
   output logic             SF,
   output logic             ZF,
   output logic             CF,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERR
);

   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0100;
   localparam logic [3:0] OP_OR  = 4'b0101;
   localparam logic [3:0] OP_XOR = 4'b0110;
   localparam logic [3:0] OP_NOT = 4'b0111;
   localparam logic [3:0] OP_SHL = 4'b1000;
   localparam logic [3:0] OP_SHR = 4'b1001;
`ifdef ALU_MUL_EN
   localparam logic [3:0] OP_MUL = 4'b1010;
`endif

   localparam int               MSB   = WIDTH - 1;
   localparam logic [WIDTH-1:0] W_VAL = WIDTH[WIDTH-1:0];

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC
`ifdef ALU_MUL_EN
      , ST_MUL
`endif
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [3:0]       op_q;
   logic             sgn_q;
   logic [WIDTH-1:0] result_q;

   // single-cycle datapath, evaluated from the latched operands
   logic [WIDTH:0]     sum_c;
   logic [WIDTH:0]     diff_c;
   logic [2*WIDTH-1:0] shl_wide;
   logic [2*WIDTH-1:0] shr_log;
   logic [2*WIDTH-1:0] shr_ari;
   logic               sh_in_range;
   logic [WIDTH-1:0]   res_c;
   logic               cf_c;
   logic               of_c;
   logic               sf_c;
   logic               zf_c;
   logic               err_c;

   always_comb begin
      sum_c       = {1'b0, a_q} + {1'b0, b_q};
      diff_c      = {1'b0, a_q} - {1'b0, b_q};
      shl_wide    = {{WIDTH{1'b0}}, a_q} << b_q;
      shr_log     = {a_q, {WIDTH{1'b0}}} >> b_q;
      shr_ari     = $signed({a_q, {WIDTH{1'b0}}}) >>> b_q;
      sh_in_range = (b_q != '0) && (b_q <= W_VAL);
      res_c       = '0;
      cf_c        = 1'b0;
      of_c        = 1'b0;
      err_c       = 1'b0;
      case (op_q)
         OP_ADD: begin
            res_c = sum_c[WIDTH-1:0];
            cf_c  = sum_c[WIDTH];
            of_c  = sgn_q && (a_q[MSB] == b_q[MSB]) && (res_c[MSB] != a_q[MSB]);
         end
         OP_SUB: begin
            res_c = diff_c[WIDTH-1:0];
            cf_c  = diff_c[WIDTH];
            of_c  = sgn_q && (a_q[MSB] != b_q[MSB]) && (res_c[MSB] != a_q[MSB]);
         end
         OP_AND: res_c = a_q & b_q;
         OP_OR:  res_c = a_q | b_q;
         OP_XOR: res_c = a_q ^ b_q;
         OP_NOT: res_c = ~a_q;
         OP_SHL: begin
            // bit WIDTH of the widened shift is the last bit pushed out of the top
            res_c = shl_wide[WIDTH-1:0];
            cf_c  = sh_in_range && shl_wide[WIDTH];
         end
         OP_SHR: begin
            res_c = sgn_q ? shr_ari[2*WIDTH-1:WIDTH] : shr_log[2*WIDTH-1:WIDTH];
            cf_c  = sh_in_range && (sgn_q ? shr_ari[WIDTH-1] : shr_log[WIDTH-1]);
         end
         default: err_c = 1'b1;
      endcase
      sf_c = sgn_q && res_c[MSB];
      zf_c = !err_c && (res_c == '0);
   end

`ifdef ALU_MUL_EN
   localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0]   mcand_q;
   logic [WIDTH-1:0]   acc_hi_q;
   logic [WIDTH-1:0]   acc_lo_q;
   logic               neg_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   hi_nx;
   logic [WIDTH-1:0]   lo_nx;
   logic [2*WIDTH-1:0] prod_mag;
   logic [2*WIDTH-1:0] prod;
   logic               prod_ovf;

   always_comb begin
      mag_a    = (SIGNED_MODE && A[MSB]) ? (~A + 1'b1) : A;
      mag_b    = (SIGNED_MODE && B[MSB]) ? (~B + 1'b1) : B;
      mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
      hi_nx    = mul_sum[WIDTH:1];
      lo_nx    = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
      prod_mag = {hi_nx, lo_nx};
      prod     = neg_q ? (~prod_mag + 1'b1) : prod_mag;
      prod_ovf = sgn_q ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[MSB]}})
                       : (prod[2*WIDTH-1:WIDTH] != '0);
   end
`endif

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state    <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         sgn_q    <= 1'b0;
         result_q <= '0;
         PROD_HI  <= '0;
         OF       <= 1'b0;
         SF       <= 1'b0;
         ZF       <= 1'b0;
         CF       <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         ERR      <= 1'b0;
`ifdef ALU_MUL_EN
         mcand_q  <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         neg_q    <= 1'b0;
         cnt_q    <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               DONE <= 1'b0;
               if (START) begin
                  a_q   <= A;
                  b_q   <= B;
                  op_q  <= OPCODE;
                  sgn_q <= SIGNED_MODE;
                  BUSY  <= 1'b1;
                  state <= ST_EXEC;
`ifdef ALU_MUL_EN
                  if (OPCODE == OP_MUL) begin
                     // multiply magnitudes; the sign is reapplied on the last step
                     mcand_q  <= mag_a;
                     acc_lo_q <= mag_b;
                     acc_hi_q <= '0;
                     neg_q    <= SIGNED_MODE && (A[MSB] ^ B[MSB]);
                     cnt_q    <= CNT_INIT;
                     state    <= ST_MUL;
                  end
`endif
               end
            end
            ST_EXEC: begin
               result_q <= res_c;
               PROD_HI  <= '0;
               CF       <= cf_c;
               OF       <= of_c;
               SF       <= sf_c;
               ZF       <= zf_c;
               ERR      <= err_c;
               BUSY     <= 1'b0;
               DONE     <= 1'b1;
               state    <= ST_IDLE;
            end
`ifdef ALU_MUL_EN
            ST_MUL: begin
               if (cnt_q == '0) begin
                  result_q <= prod[WIDTH-1:0];
                  PROD_HI  <= prod[2*WIDTH-1:WIDTH];
                  CF       <= prod_ovf;
                  OF       <= prod_ovf;
                  SF       <= sgn_q && prod[2*WIDTH-1];
                  ZF       <= (prod == '0);
                  ERR      <= 1'b0;
                  BUSY     <= 1'b0;
                  DONE     <= 1'b1;
                  state    <= ST_IDLE;
               end else begin
                  acc_hi_q <= hi_nx;
                  acc_lo_q <= lo_nx;
                  cnt_q    <= cnt_q - 1'b1;
               end
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign ALU_OUT = OE ? result_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8); MUL expectations follow ALU_MUL_EN.
module tb_alu_seq;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       START;
   logic [3:0] OPCODE;
   logic       SIGNED_MODE;
   logic [7:0] A;
   logic [7:0] B;
   logic       OE;
   wire  [7:0] ALU_OUT;
   logic [7:0] PROD_HI;
   logic       OF, SF, ZF, CF, BUSY, DONE, ERR;

   alu_seq #(.WIDTH(8)) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .OPCODE(OPCODE),
      .SIGNED_MODE(SIGNED_MODE), .A(A), .B(B), .OE(OE), .ALU_OUT(ALU_OUT),
      .PROD_HI(PROD_HI), .OF(OF), .SF(SF), .ZF(ZF), .CF(CF), .BUSY(BUSY),
      .DONE(DONE), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] res;
      logic [7:0] hi;
      logic       ofl, sf, zf, cf, err;
      int         lat;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [3:0] op, input logic sg,
                                  input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      int   ua, ub, sa, sb_, r, k;
      logic [15:0] p;
      e.res = '0; e.hi = '0; e.ofl = 0; e.sf = 0; e.zf = 0; e.cf = 0; e.err = 0;
      e.lat = 1;
      ua = a; ub = b; sa = $signed(a); sb_ = $signed(b); k = ub;
      case (op)
         4'h2: begin
            r = ua + ub; e.res = r[7:0]; e.cf = (r > 255);
            e.ofl = sg && ((sa + sb_) > 127 || (sa + sb_) < -128);
         end
         4'h3: begin
            r = ua - ub; e.res = r[7:0]; e.cf = (ua < ub);
            e.ofl = sg && ((sa - sb_) > 127 || (sa - sb_) < -128);
         end
         4'h4: e.res = a & b;
         4'h5: e.res = a | b;
         4'h6: e.res = a ^ b;
         4'h7: e.res = ~a;
         4'h8: begin
            e.res = (k >= 8) ? 8'h00 : 8'((ua << k) & 255);
            e.cf  = (k >= 1 && k <= 8) ? a[8-k] : 1'b0;
         end
         4'h9: begin
            if (sg) e.res = (k >= 8) ? {8{a[7]}} : 8'(sa >>> k);
            else    e.res = (k >= 8) ? 8'h00 : 8'(ua >> k);
            e.cf = (k >= 1 && k <= 8) ? a[k-1] : 1'b0;
         end
`ifdef ALU_MUL_EN
         4'hA: begin
            r = sg ? sa * sb_ : ua * ub;
            p = r[15:0];
            e.res = p[7:0]; e.hi = p[15:8];
            e.cf  = sg ? (r > 127 || r < -128) : (r > 255);
            e.ofl = e.cf;
            e.sf  = sg && p[15];
            e.zf  = (r == 0);
            e.lat = 8;
            return e;
         end
`endif
         default: begin
            e.err = 1'b1;
            return e;
         end
      endcase
      e.sf = sg && e.res[7];
      e.zf = (e.res == 8'h00);
      return e;
   endfunction

   // Drives one op now, waits for DONE and compares against the popped entry.
   task automatic run_op(input logic [3:0] op, input logic sg,
                         input logic [7:0] a, input logic [7:0] b, input bit poke);
      exp_t e;
      exp_t got;
      int   edges;
      bit   seen;
      e = model(op, sg, a, b);
      sb.push_back(e);
      OPCODE = op; SIGNED_MODE = sg; A = a; B = b; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      edges = 0;
      seen  = 0;
      while (!seen && edges < 40) begin
         @(posedge CLK); #1;
         edges++;
         if (DONE) seen = 1;
         else begin
            if (poke && edges == 2) begin
               START = 1'b1; OPCODE = 4'h2; A = 8'h11; B = 8'h22; SIGNED_MODE = 1'b0;
            end else START = 1'b0;
            chk("busy", BUSY, 1);
         end
      end
      START = 1'b0;
      got = sb.pop_front();
      chk("latency", edges, got.lat);
      if (seen) begin
         chk("busy_done", BUSY, 0);
         chk("alu_out", ALU_OUT, got.res);
         chk("prod_hi", PROD_HI, got.hi);
         chk("flags_osz_c_err", {OF, SF, ZF, CF, ERR},
             {got.ofl, got.sf, got.zf, got.cf, got.err});
      end
   endtask

   logic [7:0] zz;

   initial begin
      zz = {8{1'bz}};
      RST_N = 1'b0; START = 1'b0; OPCODE = '0; SIGNED_MODE = 1'b0;
      A = '0; B = '0; OE = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      chk("reset_state", {PROD_HI, ALU_OUT, OF, SF, ZF, CF, BUSY, DONE, ERR}, 0);
      RST_N = 1'b1;
      @(posedge CLK); #1;

      run_op(4'h2, 1'b0, 8'hFF, 8'h01, 0);
      run_op(4'h2, 1'b1, 8'h7F, 8'h01, 0);
      OE = 1'b0; #1;
      chk("oe_z", ALU_OUT, zz);
      OE = 1'b1; #1;
      chk("oe_keep", ALU_OUT, 8'h80);
      run_op(4'h3, 1'b0, 8'h05, 8'h07, 0);
      run_op(4'h9, 1'b1, 8'h80, 8'h09, 0);
      run_op(4'hA, 1'b1, 8'hFD, 8'h05, 1);
      repeat (3) begin
         @(posedge CLK); #1;
         chk("no_queue_done", DONE, 0);
         chk("no_queue_busy", BUSY, 0);
      end
      run_op(4'hF, 1'b0, 8'h12, 8'h34, 0);
      run_op(4'h8, 1'b0, 8'h81, 8'h01, 0);
      run_op(4'h8, 1'b1, 8'h81, 8'h08, 0);
      run_op(4'h9, 1'b0, 8'h81, 8'h08, 0);
      run_op(4'h9, 1'b0, 8'h81, 8'h00, 0);
      run_op(4'h4, 1'b1, 8'hF0, 8'h9C, 0);
      run_op(4'h5, 1'b0, 8'h00, 8'h00, 0);
      run_op(4'h6, 1'b1, 8'hA5, 8'h5A, 0);
      run_op(4'h7, 1'b0, 8'hFF, 8'h00, 0);
      run_op(4'hA, 1'b0, 8'hFF, 8'hFF, 0);
      run_op(4'hA, 1'b1, 8'h80, 8'h80, 0);
      run_op(4'hA, 1'b1, 8'h00, 8'h9B, 0);
      run_op(4'h3, 1'b1, 8'h80, 8'h01, 0);

      // abort a multiply in its third cycle
      OPCODE = 4'hA; SIGNED_MODE = 1'b0; A = 8'h0F; B = 8'h0F; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RST_N = 1'b0;
      @(posedge CLK); #1;
      chk("abort_state", {PROD_HI, ALU_OUT, OF, SF, ZF, CF, BUSY, DONE, ERR}, 0);
      RST_N = 1'b1;
      repeat (10) begin
         @(posedge CLK); #1;
         chk("abort_no_done", DONE, 0);
      end
      run_op(4'h2, 1'b0, 8'h10, 8'h20, 0);

      for (int i = 0; i < 40; i++) begin
         logic [3:0] op;
         logic [7:0] bv;
         op = 4'($urandom_range(0, 15));
         bv = (op == 4'h8 || op == 4'h9) ? 8'($urandom_range(0, 10)) : 8'($urandom);
         run_op(op, 1'($urandom), 8'($urandom), bv, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width (WIDTH >= 4).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port START  input  1  operation request, sampled only when BUSY=0.
REQ-005 SHALL have port OPCODE  input  4  operation select.
REQ-006 SHALL have port SIGNED_MODE  input  1  1=two's-complement operation, 0=unsigned.
REQ-007 SHALL have port A  input  WIDTH  operand A.
REQ-008 SHALL have port B  input  WIDTH  operand B, or the shift amount.
REQ-009 SHALL have port OE  input  1  output enable for ALU_OUT.
REQ-010 SHALL have port ALU_OUT  output  WIDTH  result low half; high-Z when OE=0.
REQ-011 SHALL have port PROD_HI  output  WIDTH  multiply product high half; 0 for all other ops.
REQ-012 SHALL have ports OF, SF, ZF, CF  output  1 each  registered flags.
REQ-013 SHALL have port BUSY  output  1  operation in progress.
REQ-014 SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-015 SHALL have port ERR  output  1  illegal opcode on the last completed operation.

Function
REQ-016 SHALL decode OPCODE as follows: 0010 ADD, 0011 SUB, 0100 AND, 0101 OR, 0110 XOR, 0111 NOT(A), 1000 SHL, 1001 SHR, 1010 MUL; all other codes are illegal.
REQ-017 SHALL implement an FSM with states IDLE, EXEC and MUL. In IDLE, START=1 latches A, B, OPCODE and SIGNED_MODE at edge N; the FSM then enters MUL for MUL, otherwise EXEC.
REQ-018 SHALL register the result, flags and ERR at edge N+1 for non-MUL ops and at edge N+WIDTH for MUL (one shift-add iteration per cycle); the FSM returns to IDLE at that same edge.
REQ-019 SHALL drive BUSY=1 only while in EXEC or MUL; START while BUSY=1 SHALL be ignored and SHALL NOT be queued.
REQ-020 SHALL assert DONE for exactly the one cycle after the completing edge; START in that cycle is accepted (back-to-back operation).
REQ-021 SHALL hold ALU_OUT, PROD_HI, flags and ERR from the last completion until the next completion.
REQ-022 SHALL compute ADD and SUB modulo 2^WIDTH; CF = carry out (ADD) or borrow, A<B unsigned (SUB).
REQ-023 SHALL, when SIGNED_MODE=1, set OF = two's-complement overflow and SF = result MSB; when SIGNED_MODE=0, force OF=SF=0.
REQ-024 SHALL set ZF=1 iff the result (for MUL, the full 2*WIDTH product) is zero, for every legal op.
REQ-025 SHALL force CF=OF=0 for AND, OR, XOR and NOT; SF follows REQ-023.
REQ-026 SHALL shift by the unsigned value of B. SHR is arithmetic when SIGNED_MODE=1, otherwise logical. If B >= WIDTH, the result is all zeros (SHL, logical SHR) or all sign bits (arithmetic SHR).
REQ-027 SHALL set CF on a shift to the last bit shifted out when 1 <= B <= WIDTH, and to 0 otherwise; OF=0.
REQ-028 SHALL form the MUL product {PROD_HI, ALU_OUT} as the full 2*WIDTH product; signed MUL multiplies magnitudes and negates the product when the operand signs differ.
REQ-029 SHALL, for MUL, set CF=OF=1 when the product does not fit in WIDTH bits (unsigned: PROD_HI != 0; signed: PROD_HI not the sign extension of ALU_OUT); SF = product MSB when SIGNED_MODE=1.
REQ-030 SHALL, for an illegal opcode, complete at N+1 with ERR=1, ALU_OUT=0, PROD_HI=0 and all flags 0; every legal completion clears ERR.
REQ-031 SHALL drive ALU_OUT combinationally from the result register when OE=1 and all-Z when OE=0; OE SHALL NOT affect the stored result.

Reset
REQ-032 SHALL, when RST_N=0 at a rising edge, enter IDLE and clear the result register, PROD_HI, OF, SF, ZF, CF, BUSY, DONE and ERR, overriding START.
REQ-033 SHALL abort an in-progress MUL on reset with no DONE pulse; the first START after RST_N returns to 1 is accepted normally.

Configuration
REQ-034 SHALL, with macro ALU_MUL_EN defined, implement MUL and the MUL state as specified above.
REQ-035 SHALL, without ALU_MUL_EN, omit the multiplier and MUL state, treat 1010 as illegal per REQ-030, and tie PROD_HI to 0.

Verification (WIDTH=8, ALU_MUL_EN defined, OE=1)
REQ-036 Unsigned ADD, A=0xFF, B=0x01 -> ALU_OUT=0x00, ZF=1, CF=1, OF=0, SF=0; DONE high one cycle after the edge following acceptance.
REQ-037 Signed ADD, A=0x7F, B=0x01 -> ALU_OUT=0x80, OF=1, SF=1, CF=0, ZF=0.
REQ-038 Unsigned SUB, A=0x05, B=0x07 -> ALU_OUT=0xFE, CF=1, SF=0, OF=0; arithmetic SHR of A=0x80 with B=9 -> ALU_OUT=0xFF, CF=0.
REQ-039 Signed MUL, A=0xFD, B=0x05 -> PROD_HI=0xFF, ALU_OUT=0xF1, SF=1, OF=CF=0; BUSY high 8 cycles; DONE 8 edges after acceptance; START during BUSY ignored.
REQ-040 RST_N=0 during the 3rd MUL cycle -> at the next edge all outputs are 0 and BUSY=0, with no DONE; OPCODE=1111 -> ERR=1, ALU_OUT=0; OE=0 -> ALU_OUT=Z.
